// File: rtl/sram_controller_if.sv
// sram_controller_if
// Memory-stage request bus between the CPU pipeline and the SRAM controller.
//   wr_en, rd_en : store / load request. Held by the pipeline until ready=1.
//   address      : ARM byte address. The data region starts at 1024.
//   write_data   : store data. Stable while wr_en=1.
//   read_data    : assembled 32-bit load word.
//   ready        : 0 while an access is pending. Drives the pipeline freeze.
// Modports: master = pipeline side, slave = controller side.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// sram_controller
// Bridges 32-bit MEM-stage loads and stores onto a 16-bit asynchronous SRAM.
// Each word is moved in two half-word phases: LOW first, then HIGH.
// Each phase lasts WAIT_CYCLES+1 cycles.
// Ports:
//   clk          : single clock. All state updates on its rising edge.
//   rst          : asynchronous active-low reset.
//   bus          : pipeline request bus (sram_controller_if.slave).
//   sram_addr    : half-word SRAM address.
//   sram_dq_out  : SRAM write data. Driven onto the pads when sram_dq_oe=1.
//   sram_dq_in   : SRAM read data from the pads.
//   sram_dq_oe   : enable for the external tristate driver.
//   sram_we_n    : active-low SRAM write strobe.
//   sram_oe_n    : active-low SRAM output strobe.
module sram_controller #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output logic [17:0]       sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic [16:0] word_off;
  logic        last_cyc;
  logic        start;

  assign last_cyc = (cnt == LAST);
  assign start    = (state == IDLE) && (state_nxt == LOW);

  // The offset wraps modulo 2^32 and is not range checked.
  // Only bits [18:2] of the difference form the word offset.
  assign word_off = 17'((addr_q - 32'd1024) >> 2);

  assign bus.read_data = read_data_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic. Requests seen in DONE are ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.wr_en || bus.rd_en) state_nxt = LOW;
      LOW:     if (last_cyc) state_nxt = HIGH;
      HIGH:    if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle counter. Clears on every state entry and counts only in LOW and HIGH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              cnt <= '0;
    else if (state_nxt != state)           cnt <= '0;
    else if (state == LOW || state == HIGH) cnt <= cnt + 4'd1;
  end

  // The operation is latched when the access starts.
  // A request that is dropped later cannot change or abort it.
  // A combined wr_en+rd_en request is treated as a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       op_wr <= 1'b0;
    else if (start) op_wr <= bus.wr_en;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      addr_q  <= bus.address;
      wdata_q <= bus.write_data;
    end
  end

  // Read capture on the last cycle of each phase.
  // The strobe has been low for WAIT_CYCLES cycles by then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
    end else if (!op_wr && last_cyc) begin
      if (state == LOW)  read_data_q[15:0]  <= sram_dq_in;
      if (state == HIGH) read_data_q[31:16] <= sram_dq_in;
    end
  end

  // Output decode.
  // Write: we_n rises on the last cycle of each phase while address and data stay put.
  // ready is combinational, so the pipeline freezes in the same cycle as the request.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    bus.ready   = (state == DONE) ||
                  ((state == IDLE) && !bus.wr_en && !bus.rd_en);
    if (state == LOW || state == HIGH) begin
      sram_addr = {word_off, (state == HIGH)};
      if (op_wr) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = last_cyc;
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Directed bench for sram_controller with WAIT_CYCLES=1.
// An SRAM model of 256 half-words stores data on each rising edge of sram_we_n.
// Each scenario task compares the packed bus outputs cycle by cycle
// against hand-written tables.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int vectors = 0;
  int errors  = 0;
  int we_falls = 0;

  logic [15:0] mem [256];
  logic [37:0] obs;

  sram_controller_if bus();

  sram_controller #(.WAIT_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];
  assign obs = {bus.ready, sram_we_n, sram_oe_n, sram_dq_oe, sram_addr, sram_dq_out};

  // SRAM model: a write lands when we_n rises while reset is released.
  initial begin
    logic we_prev;
    we_prev = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8] = 16'hCAFE;
    mem[9] = 16'hF00D;
    forever begin
      @(negedge clk);
      if (rst && !we_prev && sram_we_n) mem[sram_addr[7:0]] = sram_dq_out;
      we_prev = sram_we_n;
    end
  end

  initial forever begin
    @(negedge sram_we_n);
    we_falls++;
  end

  function automatic logic [37:0] pk(bit rdy, bit we, bit oe, bit doe,
                                     logic [17:0] a, logic [15:0] d);
    return {rdy, we, oe, doe, a, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.write_data = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== pk(1,1,1,0,0,0)) begin
      errors++; $display("FAIL reset_outputs: got %h want %h", obs, pk(1,1,1,0,0,0));
    end
    vectors++;
    if (bus.read_data !== 32'h0) begin
      errors++; $display("FAIL reset_read_data: got %h want 00000000", bus.read_data);
    end
    #2 rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== pk(1,1,1,0,0,0)) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs, pk(1,1,1,0,0,0));
    end
  endtask

  task automatic test_write();
    logic [37:0] exp [6];
    exp[0] = pk(0,1,1,0,0,0);
    exp[1] = pk(0,0,1,1,0,16'hBEEF);
    exp[2] = pk(0,1,1,1,0,16'hBEEF);
    exp[3] = pk(0,0,1,1,1,16'hDEAD);
    exp[4] = pk(0,1,1,1,1,16'hDEAD);
    exp[5] = pk(1,1,1,0,0,0);
    step();
    bus.wr_en = 1; bus.address = 32'd1024; bus.write_data = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL write c%0d: got %h want %h", c, obs, exp[c]);
      end
    end
    vectors++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
      errors++; $display("FAIL write_mem: got %h%h want DEADBEEF", mem[1], mem[0]);
    end
    step();
    bus.wr_en = 0;
  endtask

  task automatic test_read();
    logic [37:0] exp [6];
    exp[0] = pk(0,1,1,0,0,0);
    exp[1] = pk(0,1,0,0,0,0);
    exp[2] = pk(0,1,0,0,0,0);
    exp[3] = pk(0,1,0,0,1,0);
    exp[4] = pk(0,1,0,0,1,0);
    exp[5] = pk(1,1,1,0,0,0);
    step();
    bus.rd_en = 1; bus.address = 32'd1024;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL read c%0d: got %h want %h", c, obs, exp[c]);
      end
      if (c == 3) begin
        vectors++;
        if (bus.read_data !== 32'h0000BEEF) begin
          errors++; $display("FAIL read_low_half: got %h want 0000BEEF", bus.read_data);
        end
      end
    end
    vectors++;
    if (bus.read_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h want DEADBEEF", bus.read_data);
    end
    step();
    bus.rd_en = 0;
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp [12];
    exp[0]  = pk(0,1,1,0,0,0);
    exp[1]  = pk(0,0,1,1,2,16'h5678);
    exp[2]  = pk(0,1,1,1,2,16'h5678);
    exp[3]  = pk(0,0,1,1,3,16'h1234);
    exp[4]  = pk(0,1,1,1,3,16'h1234);
    exp[5]  = pk(1,1,1,0,0,0);
    exp[6]  = pk(0,1,1,0,0,0);
    exp[7]  = pk(0,1,0,0,2,0);
    exp[8]  = pk(0,1,0,0,2,0);
    exp[9]  = pk(0,1,0,0,3,0);
    exp[10] = pk(0,1,0,0,3,0);
    exp[11] = pk(1,1,1,0,0,0);
    step();
    bus.wr_en = 1; bus.address = 32'd1028; bus.write_data = 32'h12345678;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL b2b c%0d: got %h want %h", c, obs, exp[c]);
      end
      if (c == 5) begin
        step();
        bus.wr_en = 0; bus.rd_en = 1;
      end
    end
    vectors++;
    if (bus.read_data !== 32'h12345678) begin
      errors++; $display("FAIL b2b_read_data: got %h want 12345678", bus.read_data);
    end
    step();
    bus.rd_en = 0;
  endtask

  task automatic test_both_requests();
    logic [37:0] exp [6];
    exp[0] = pk(0,1,1,0,0,0);
    exp[1] = pk(0,0,1,1,4,16'h5A5A);
    exp[2] = pk(0,1,1,1,4,16'h5A5A);
    exp[3] = pk(0,0,1,1,5,16'hA5A5);
    exp[4] = pk(0,1,1,1,5,16'hA5A5);
    exp[5] = pk(1,1,1,0,0,0);
    step();
    bus.wr_en = 1; bus.rd_en = 1; bus.address = 32'd1032; bus.write_data = 32'hA5A55A5A;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL both c%0d: got %h want %h", c, obs, exp[c]);
      end
    end
    vectors++;
    if (mem[4] !== 16'h5A5A || mem[5] !== 16'hA5A5) begin
      errors++; $display("FAIL both_mem: got %h%h want A5A55A5A", mem[5], mem[4]);
    end
    vectors++;
    if (bus.read_data !== 32'h12345678) begin
      errors++; $display("FAIL both_read_data_kept: got %h want 12345678", bus.read_data);
    end
    step();
    bus.wr_en = 0; bus.rd_en = 0;
  endtask

  task automatic test_dropped_request();
    logic [37:0] exp [7];
    exp[0] = pk(0,1,1,0,0,0);
    exp[1] = pk(0,1,0,0,8,0);
    exp[2] = pk(0,1,0,0,8,0);
    exp[3] = pk(0,1,0,0,9,0);
    exp[4] = pk(0,1,0,0,9,0);
    exp[5] = pk(1,1,1,0,0,0);
    exp[6] = pk(1,1,1,0,0,0);
    step();
    bus.rd_en = 1; bus.address = 32'd1040;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL drop c%0d: got %h want %h", c, obs, exp[c]);
      end
      if (c == 0) begin
        step();
        bus.rd_en = 0;
      end
    end
    vectors++;
    if (bus.read_data !== 32'hF00DCAFE) begin
      errors++; $display("FAIL drop_read_data: got %h want F00DCAFE", bus.read_data);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== pk(1,1,1,0,0,0) || bus.read_data !== 32'hF00DCAFE) begin
        errors++;
        $display("FAIL idle c%0d: got %h/%h want %h/F00DCAFE", c, obs, bus.read_data,
                 pk(1,1,1,0,0,0));
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [37:0] exp [4];
    int falls_before;
    exp[0] = pk(0,1,1,0,0,0);
    exp[1] = pk(0,0,1,1,6,16'h2222);
    exp[2] = pk(0,1,1,1,6,16'h2222);
    exp[3] = pk(0,0,1,1,7,16'h1111);
    step();
    bus.wr_en = 1; bus.address = 32'd1036; bus.write_data = 32'h11112222;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (obs !== exp[c]) begin
        errors++; $display("FAIL rstmid c%0d: got %h want %h", c, obs, exp[c]);
      end
    end
    #2 rst = 1'b0;
    #1;
    falls_before = we_falls;
    vectors++;
    if (obs !== pk(0,1,1,0,0,0) || bus.read_data !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: got %h/%h want %h/00000000", obs, bus.read_data,
               pk(0,1,1,0,0,0));
    end
    bus.wr_en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (obs !== pk(1,1,1,0,0,0)) begin
      errors++; $display("FAIL rstmid_release: got %h want %h", obs, pk(1,1,1,0,0,0));
    end
    vectors++;
    if (we_falls !== falls_before) begin
      errors++; $display("FAIL rstmid_no_pulse: got %0d falls want %0d", we_falls, falls_before);
    end
    vectors++;
    if (mem[6] !== 16'h2222 || mem[7] !== 16'h0000) begin
      errors++; $display("FAIL rstmid_mem: got %h%h want 00002222", mem[7], mem[6]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_requests();
    test_dropped_request();
    test_idle();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
